// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision FP adder constants and helpers
package fp_pkg;

    localparam int SP_WIDTH = 32;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2_f(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gp_prefix_cell.sv
// rtl/gp_prefix_cell.sv - generate/propagate combine cell for the prefix tree
module gp_prefix_cell (
    input  logic gi,
    input  logic pi,
    input  logic gj,
    input  logic pj,
    output logic g,
    output logic p
);

    assign g = gi | (pi & gj);
    assign p = pi & pj;

endmodule

// File: rtl/recursive_doubling_adder.sv
// rtl/recursive_doubling_adder.sv - pipelined Kogge-Stone adder for the FP mantissa path
module recursive_doubling_adder
    import fp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = clog2_f(WIDTH);

    // Stage register k holds G/P after k prefix levels; h rides alongside.
    logic [LEVELS-1:0][WIDTH-1:0] g_q;
    logic [LEVELS-1:0][WIDTH-1:0] p_q;
    logic [LEVELS-1:0][WIDTH-1:0] h_q;

    logic [LEVELS:1][WIDTH-1:0]   g_nx;
    logic [LEVELS:1][WIDTH-1:0]   p_nx;

    logic [WIDTH-1:0]             carry;
    logic [WIDTH-1:0]             sum_nx;
    logic                         unused_p;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int D = 1 << (k - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_cell
                gp_prefix_cell u_cell (
                    .gi (g_q[k-1][i]),
                    .pi (p_q[k-1][i]),
                    .gj (g_q[k-1][i-D]),
                    .pj (p_q[k-1][i-D]),
                    .g  (g_nx[k][i]),
                    .p  (p_nx[k][i])
                );
            end else begin : g_pass
                assign g_nx[k][i] = g_q[k-1][i];
                assign p_nx[k][i] = p_q[k-1][i];
            end
        end
    end

    // Final-level propagate is not needed once every carry is resolved.
    assign unused_p = ^p_nx[LEVELS];

    assign carry  = g_nx[LEVELS];
    assign sum_nx = h_q[LEVELS-1] ^ {carry[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q  <= '0;
            p_q  <= '0;
            h_q  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            g_q[0] <= a & b;
            p_q[0] <= a ^ b;
            h_q[0] <= a ^ b;
            for (int k = 1; k < LEVELS; k++) begin
                g_q[k] <= g_nx[k];
                p_q[k] <= p_nx[k];
                h_q[k] <= h_q[k-1];
            end
            sum  <= sum_nx;
            cout <= carry[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_recursive_doubling_adder.sv
// tb/tb_recursive_doubling_adder.sv - directed self-checking bench for recursive_doubling_adder
module tb_recursive_doubling_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] sum;
    logic        cout;

    int total = 0;
    int bad = 0;

    recursive_doubling_adder #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        a = '0;
        b = '0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset();
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (sum !== 32'h0 || cout !== 1'b0) begin
            bad++;
            $display("FAIL reset_immediate: got %h/%b want 00000000/0", sum, cout);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (sum !== 32'h0 || cout !== 1'b0) begin
                bad++;
                $display("FAIL reset_held[%0d]: got %h/%b want 00000000/0", i, sum, cout);
            end
        end
        rst_n = 1'b1;
        a = '0;
        b = '0;
    endtask

    task automatic test_simple();
        flush();
        a = 32'h0000_0001;
        b = 32'h0000_0001;
        tick();
        a = '0;
        b = '0;
        for (int e = 2; e <= 5; e++) begin
            tick();
            total++;
            if (sum !== 32'h0 || cout !== 1'b0) begin
                bad++;
                $display("FAIL simple_hold_edge%0d: got %h/%b want 00000000/0", e, sum, cout);
            end
        end
        tick();
        total++;
        if (sum !== 32'h0000_0002 || cout !== 1'b0) begin
            bad++;
            $display("FAIL simple_result: got %h/%b want 00000002/0", sum, cout);
        end
    endtask

    task automatic test_full_carry();
        flush();
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        tick();
        a = '0;
        b = '0;
        for (int e = 2; e <= 5; e++) tick();
        total++;
        if (sum !== 32'h0 || cout !== 1'b0) begin
            bad++;
            $display("FAIL full_carry_edge5: got %h/%b want 00000000/0", sum, cout);
        end
        tick();
        total++;
        if (sum !== 32'h0000_0000 || cout !== 1'b1) begin
            bad++;
            $display("FAIL full_carry_result: got %h/%b want 00000000/1", sum, cout);
        end
    endtask

    task automatic test_twos_comp();
        flush();
        a = 32'hFF05_FFFF;
        b = 32'h0000_0001;
        tick();
        a = '0;
        b = '0;
        for (int e = 2; e <= 6; e++) tick();
        total++;
        if (sum !== 32'hFF06_0000 || cout !== 1'b0) begin
            bad++;
            $display("FAIL twos_comp_result: got %h/%b want ff060000/0", sum, cout);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] es [3];
        logic        ec [3];
        va = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678};
        vb = '{32'h0000_0001, 32'h8000_0000, 32'h8765_4321};
        es = '{32'h8000_0000, 32'h0000_0000, 32'h9999_9999};
        ec = '{1'b0, 1'b1, 1'b0};
        flush();
        for (int i = 0; i < 3; i++) begin
            a = va[i];
            b = vb[i];
            tick();
        end
        a = '0;
        b = '0;
        tick();
        tick();
        total++;
        if (sum !== 32'h0 || cout !== 1'b0) begin
            bad++;
            $display("FAIL b2b_edge5: got %h/%b want 00000000/0", sum, cout);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (sum !== es[i] || cout !== ec[i]) begin
                bad++;
                $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", i, sum, cout, es[i], ec[i]);
            end
        end
        tick();
        total++;
        if (sum !== 32'h0 || cout !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: got %h/%b want 00000000/0", sum, cout);
        end
    endtask

    task automatic test_mid_reset();
        flush();
        for (int i = 1; i <= 4; i++) begin
            a = 32'h1111_1111 * i;
            b = 32'h0101_0101 * i;
            tick();
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (sum !== 32'h0 || cout !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_async: got %h/%b want 00000000/0", sum, cout);
        end
        #1 rst_n = 1'b1;
        a = 32'h0000_0003;
        b = 32'h0000_0004;
        tick();
        a = '0;
        b = '0;
        for (int e = 2; e <= 5; e++) begin
            tick();
            total++;
            if (sum !== 32'h0 || cout !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_no_stale_edge%0d: got %h/%b want 00000000/0", e, sum, cout);
            end
        end
        tick();
        total++;
        if (sum !== 32'h0000_0007 || cout !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_result: got %h/%b want 00000007/0", sum, cout);
        end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_full_carry();
        test_twos_comp();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
